// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

   // Read-port presentation modes selected by the FWFT parameter
   localparam int FWFT_STD = 0;
   localparam int FWFT_ON  = 1;

   // Pointers and the level counter carry one extra bit so that
   // DEPTH itself is representable and full/empty are unambiguous.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ram_dp_2clk.sv
// Simple dual-port RAM: one write port, one registered read port, each on its own clock.
module ram_dp_2clk #(
   parameter int    WIDTH    = 32,
   parameter int    DEPTH    = 64,
   parameter string RAM_TYPE = "block",
   localparam int   AW       = $clog2(DEPTH)
) (
   input  logic             wr_clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_clk_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   generate
      if (RAM_TYPE == "distributed") begin : g_dist
         (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

         // Write port
         always_ff @(posedge wr_clk_i) begin
            if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
         end

         // Registered read port (returns old contents on a same-address write)
         always_ff @(posedge rd_clk_i) begin
            if (rd_en_i) rd_data_o <= mem[rd_addr_i];
         end
      end else begin : g_block
         (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

         // Write port
         always_ff @(posedge wr_clk_i) begin
            if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
         end

         // Registered read port (returns old contents on a same-address write)
         always_ff @(posedge rd_clk_i) begin
            if (rd_en_i) rd_data_o <= mem[rd_addr_i];
         end
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, level, status-flag and sticky-error bookkeeping for sync_fifo.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int  DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = level_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          empty_i,        // externally visible empty (mode dependent)
   input  logic [LW-1:0] a_full_thr_i,
   input  logic [LW-1:0] a_empty_thr_i,
   output logic          wr_en_o,
   output logic          rd_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [AW-1:0] rd_addr_o,
   output logic [AW-1:0] rd_addr_next_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          a_full_o,
   output logic          a_empty_o,
   output logic          level_zero_o,
   output logic          overflow_o,
   output logic          underflow_o
);

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          a_full_q, a_full_d;
   logic          a_empty_q, a_empty_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          wr_en, rd_en;

   // Accept/drop decisions and next-state of pointers, level and flags
   always_comb begin
      wr_en    = push_i & ~full_q & ~clr_i;
      rd_en    = pop_i & ~empty_i & ~clr_i;
      wr_ptr_d = wr_ptr_q + LW'(wr_en);
      rd_ptr_d = rd_ptr_q + LW'(rd_en);
      level_d  = level_q + LW'(wr_en) - LW'(rd_en);
      ovf_d    = ovf_q | (push_i & full_q);
      udf_d    = udf_q | (pop_i & empty_i);
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
      full_d    = (level_d == LW'(DEPTH));
      a_full_d  = (level_d >= a_full_thr_i);
      a_empty_d = (level_d <= a_empty_thr_i);
      zero_d    = (level_d == '0);
   end

   // State registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         a_full_q  <= 1'b0;
         a_empty_q <= 1'b1;
         zero_q    <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         full_q    <= full_d;
         a_full_q  <= a_full_d;
         a_empty_q <= a_empty_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   assign wr_en_o        = wr_en;
   assign rd_en_o        = rd_en;
   assign wr_addr_o      = wr_ptr_q[AW-1:0];
   assign rd_addr_o      = rd_ptr_q[AW-1:0];
   assign rd_addr_next_o = rd_ptr_d[AW-1:0];
   assign level_o        = level_q;
   assign full_o         = full_q;
   assign a_full_o       = a_full_q;
   assign a_empty_o      = a_empty_q;
   assign level_zero_o   = zero_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through read port.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int    FIFO_WIDTH = 32,
   parameter int    FIFO_DEPTH = 64,
   parameter string FIFO_TYPE  = "block",
   parameter int    FWFT       = FWFT_STD,
   localparam int   ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic [FIFO_WIDTH-1:0] wr_data_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   output logic [FIFO_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic [ADDR_WIDTH:0]   a_full_thr_i,
   input  logic [ADDR_WIDTH:0]   a_empty_thr_i,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  full_o,
   output logic                  a_full_o,
   output logic                  empty_o,
   output logic                  a_empty_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam bit IS_FWFT = (FWFT == FWFT_ON);
   localparam int LW      = ADDR_WIDTH + 1;

   logic                  wr_en, rd_en, level_zero;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, rd_addr_next;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic                  ram_rd_en;
   logic [FIFO_WIDTH-1:0] ram_rd_data;

   logic                  std_valid_q, std_valid_d;
   logic                  head_valid_q, head_valid_d;
   logic                  bypass_sel_q, bypass_sel_d;
   logic [FIFO_WIDTH-1:0] bypass_data_q;

   sync_fifo_ctrl #(.DEPTH(FIFO_DEPTH)) u_ctrl (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .clr_i          (clr_i),
      .push_i         (push_i),
      .pop_i          (pop_i),
      .empty_i        (empty_o),
      .a_full_thr_i   (a_full_thr_i),
      .a_empty_thr_i  (a_empty_thr_i),
      .wr_en_o        (wr_en),
      .rd_en_o        (rd_en),
      .wr_addr_o      (wr_addr),
      .rd_addr_o      (rd_addr),
      .rd_addr_next_o (rd_addr_next),
      .level_o        (level_o),
      .full_o         (full_o),
      .a_full_o       (a_full_o),
      .a_empty_o      (a_empty_o),
      .level_zero_o   (level_zero),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   ram_dp_2clk #(
      .WIDTH    (FIFO_WIDTH),
      .DEPTH    (FIFO_DEPTH),
      .RAM_TYPE (FIFO_TYPE)
   ) u_ram (
      .wr_clk_i  (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data_i),
      .rd_clk_i  (clk_i),
      .rd_en_i   (ram_rd_en),
      .rd_addr_i (ram_rd_addr),
      .rd_data_o (ram_rd_data)
   );

   // Read-port control. FWFT reads continuously from the post-pop address so
   // the following word is already in the RAM output register after a pop.
   // The head is valid when a word written before this edge sits at that
   // address; the only same-edge case (pop of the last word while writing its
   // successor) is served from a bypass register instead of the RAM.
   always_comb begin
      ram_rd_addr  = IS_FWFT ? rd_addr_next : rd_addr;
      ram_rd_en    = IS_FWFT ? 1'b1 : rd_en;
      std_valid_d  = rd_en;
      bypass_sel_d = wr_en & rd_en & (level_o == LW'(1));
      head_valid_d = (level_o > LW'(rd_en)) | bypass_sel_d;
      if (clr_i) begin
         bypass_sel_d = 1'b0;
         head_valid_d = 1'b0;
      end
   end

   // Read-port state registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         std_valid_q  <= 1'b0;
         head_valid_q <= 1'b0;
         bypass_sel_q <= 1'b0;
      end else begin
         std_valid_q  <= std_valid_d;
         head_valid_q <= head_valid_d;
         bypass_sel_q <= bypass_sel_d;
      end
   end

   // Bypass word capture; only meaningful while bypass_sel_q is set
   always_ff @(posedge clk_i) begin
      bypass_data_q <= wr_data_i;
   end

   assign empty_o    = IS_FWFT ? ~head_valid_q : level_zero;
   assign rd_valid_o = IS_FWFT ? head_valid_q : std_valid_q;
   assign rd_data_o  = (IS_FWFT && bypass_sel_q) ? bypass_data_q : ram_rd_data;

endmodule
